// File: rtl/tmodel_scan_ctrl.sv
// tmodel_scan_ctrl: serial test-access controller for the section harness.
// Shifts in a stimulus frame, applies it, waits a settle time, shifts out the result.
module tmodel_scan_ctrl #(
   parameter int N1  = 89,
   parameter int N2  = 79,
   parameter int LAT = 3
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Abort,
   input  logic          SDI,
   input  logic          SValid,
   output logic          SDO,
   output logic          SDOValid,
   output logic          Busy,
   output logic          Done,
   output logic [N1-1:0] TIn,
   output logic          TS1,
   output logic          TS2,
   output logic          TS3,
   input  logic [N2-1:0] TOut
);

   localparam int FW = N1 + 3;
   localparam int CW = $clog2(FW + 1);

   localparam logic [CW-1:0] LOAD_LAST = CW'(FW - 1);
   localparam logic [CW-1:0] UNL_LAST  = CW'(N2 - 1);
   localparam logic [7:0]    SET_LAST  = 8'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      APPLY  = 2'd2,
      UNLOAD = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   bit_cnt;
   logic [7:0]      settle_cnt;
   logic [FW-1:0]   frame_sr;
   logic [N2-1:0]   result_sr;
   logic            done_r;

   // State register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; Abort wins over every other input
   always_comb begin
      state_nx = state;
      if (Abort) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (Start) state_nx = LOAD;
            LOAD:    if (SValid && bit_cnt == LOAD_LAST) state_nx = APPLY;
            APPLY:   if (settle_cnt == SET_LAST) state_nx = UNLOAD;
            UNLOAD:  if (bit_cnt == UNL_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Outputs decoded from state; SDO is forced low outside UNLOAD
   always_comb begin
      Busy     = 1'b0;
      SDOValid = 1'b0;
      SDO      = 1'b0;
      unique case (state)
         IDLE:    Busy = 1'b0;
         LOAD:    Busy = 1'b1;
         APPLY:   Busy = 1'b1;
         UNLOAD: begin
            Busy     = 1'b1;
            SDOValid = 1'b1;
            SDO      = result_sr[0];
         end
         default: Busy = 1'b0;
      endcase
   end

   assign Done = done_r;

   // Datapath: frame shifting, vector apply, settle count, result unload
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         bit_cnt    <= '0;
         settle_cnt <= '0;
         frame_sr   <= '0;
         result_sr  <= '0;
         done_r     <= 1'b0;
         TIn        <= '0;
         TS1        <= 1'b0;
         TS2        <= 1'b0;
         TS3        <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (Abort) begin
            bit_cnt    <= '0;
            settle_cnt <= '0;
            frame_sr   <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (Start) begin
                     bit_cnt  <= '0;
                     frame_sr <= '0;
                  end
               end
               LOAD: begin
                  if (SValid) begin
                     frame_sr <= {SDI, frame_sr[FW-1:1]};
                     bit_cnt  <= bit_cnt + CW'(1);
                     if (bit_cnt == LOAD_LAST) begin
                        {TS3, TS2, TS1, TIn} <= {SDI, frame_sr[FW-1:1]};
                        settle_cnt <= '0;
                     end
                  end
               end
               APPLY: begin
                  settle_cnt <= settle_cnt + 8'd1;
                  if (settle_cnt == SET_LAST) begin
                     result_sr <= TOut;
                     bit_cnt   <= '0;
                  end
               end
               UNLOAD: begin
                  result_sr <= {1'b0, result_sr[N2-1:1]};
                  bit_cnt   <= bit_cnt + CW'(1);
                  if (bit_cnt == UNL_LAST) done_r <= 1'b1;
               end
               default: done_r <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tmodel_scan_ctrl.sv
// tb_tmodel_scan_ctrl: scoreboard bench for tmodel_scan_ctrl.
// Three instances: LAT=3 for the main traffic, LAT=1 and LAT=255 for the sweep.
module tb_tmodel_scan_ctrl;

   localparam int N1 = 89;
   localparam int N2 = 79;
   localparam int FW = N1 + 3;

   typedef struct {
      int   c;
      logic b;
   } sdo_e;

   typedef struct {
      int            c;
      logic [FW-1:0] v;
   } vec_e;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          sw_start;
   logic          abort;
   logic          sdi;
   logic          svalid;
   logic [2:0]    sdo;
   logic [2:0]    sdov;
   logic [2:0]    busy;
   logic [2:0]    done;
   logic [2:0]    ts1;
   logic [2:0]    ts2;
   logic [2:0]    ts3;
   logic [N1-1:0] tin  [3];
   logic [N2-1:0] tout [3];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   sdo_e          sq [3][$];
   int            dq [3][$];
   vec_e          vq [$];
   logic [FW-1:0] mv [3];
   logic [FW-1:0] cur_vec;

   tmodel_scan_ctrl #(.N1(N1), .N2(N2), .LAT(3)) u_dut0 (
      .Clock(clk), .Reset(rst), .Start(start), .Abort(abort),
      .SDI(sdi), .SValid(svalid), .SDO(sdo[0]), .SDOValid(sdov[0]),
      .Busy(busy[0]), .Done(done[0]), .TIn(tin[0]),
      .TS1(ts1[0]), .TS2(ts2[0]), .TS3(ts3[0]), .TOut(tout[0])
   );

   tmodel_scan_ctrl #(.N1(N1), .N2(N2), .LAT(1)) u_dut1 (
      .Clock(clk), .Reset(rst), .Start(sw_start), .Abort(abort),
      .SDI(sdi), .SValid(svalid), .SDO(sdo[1]), .SDOValid(sdov[1]),
      .Busy(busy[1]), .Done(done[1]), .TIn(tin[1]),
      .TS1(ts1[1]), .TS2(ts2[1]), .TS3(ts3[1]), .TOut(tout[1])
   );

   tmodel_scan_ctrl #(.N1(N1), .N2(N2), .LAT(255)) u_dut2 (
      .Clock(clk), .Reset(rst), .Start(sw_start), .Abort(abort),
      .SDI(sdi), .SValid(svalid), .SDO(sdo[2]), .SDOValid(sdov[2]),
      .Busy(busy[2]), .Done(done[2]), .TIn(tin[2]),
      .TS1(ts1[2]), .TS2(ts2[2]), .TS3(ts3[2]), .TOut(tout[2])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Harness stub: result is the stimulus, registered one cycle
   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 3; k++) begin
         if (rst) tout[k] <= '0;
         else     tout[k] <= tin[k][N2-1:0];
      end
   end

   function automatic int lat_of(input int k);
      if (k == 0) return 3;
      if (k == 1) return 1;
      return 255;
   endfunction

   function automatic logic [FW-1:0] rnd_frame();
      logic [FW-1:0] r;
      for (int i = 0; i < FW; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   task automatic chk(input string nm, input logic [FW-1:0] act,
                      input logic [FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expectations whenever an instance presents output
   always @(negedge clk) begin : mon
      int   mc;
      sdo_e e;
      int   dc;
      mc = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         if (sdov[k]) begin
            checks++;
            if (sq[k].size() == 0) begin
               failures++;
               $display("FAIL sdo_extra dut%0d cycle %0d got SDOValid=1 required none", k, mc);
            end else begin
               e = sq[k].pop_front();
               if (e.c != mc || e.b !== sdo[k]) begin
                  failures++;
                  $display("FAIL sdo dut%0d got cycle %0d bit %0b required cycle %0d bit %0b",
                           k, mc, sdo[k], e.c, e.b);
               end
            end
         end
         if (done[k]) begin
            checks++;
            if (dq[k].size() == 0) begin
               failures++;
               $display("FAIL done_extra dut%0d cycle %0d got Done=1 required none", k, mc);
            end else begin
               dc = dq[k].pop_front();
               if (dc != mc) begin
                  failures++;
                  $display("FAIL done dut%0d got cycle %0d required cycle %0d", k, mc, dc);
               end
            end
         end
      end
      if (vq.size() != 0 && vq[0].c == mc) cur_vec = vq.pop_front().v;
      if (rst) cur_vec = '0;
      checks++;
      if ({ts3[0], ts2[0], ts1[0], tin[0]} !== cur_vec) begin
         failures++;
         $display("FAIL vector cycle %0d got %0h required %0h", mc,
                  {ts3[0], ts2[0], ts1[0], tin[0]}, cur_vec);
      end
   end

   // One transaction. ab_load/ab_unl >= 0 plant an Abort at that bit.
   task automatic run_txn(input logic [FW-1:0] fr, input int stalls,
                          input int ab_load, input int ab_unl,
                          input bit sweep, input bit pulses);
      int L;
      int nst;
      int i;
      int lat_max;
      int nb;
      logic [N2-1:0] cap;
      start    = 1'b1;
      sw_start = sweep;
      svalid   = 1'($urandom_range(0, 1));
      sdi      = 1'($urandom_range(0, 1));
      step();
      start    = 1'b0;
      sw_start = 1'b0;
      if (sweep) chk("busy_start_sweep", FW'(busy), FW'(3'b111));
      else       chk("busy_start", FW'(busy[0]), FW'(1));
      nst = stalls;
      i   = 0;
      while (i < FW) begin
         if (ab_load == i) begin
            abort  = 1'b1;
            svalid = 1'b1;
            sdi    = 1'($urandom_range(0, 1));
            step();
            abort  = 1'b0;
            svalid = 1'b0;
            start  = 1'b0;
            return;
         end
         start = pulses && ($urandom_range(0, 7) == 0);
         if (nst > 0 && ($urandom_range(0, 3) == 0 || i == FW - 1)) begin
            svalid = 1'b0;
            sdi    = 1'($urandom_range(0, 1));
            nst--;
         end else begin
            svalid = 1'b1;
            sdi    = fr[i];
            i++;
         end
         step();
      end
      L = cyc;
      vq.push_back('{c: L + 1, v: fr});
      for (int k = 0; k < 3; k++) begin
         if (k == 0 || sweep) begin
            cap = (lat_of(k) >= 2) ? fr[N2-1:0] : mv[k][N2-1:0];
            nb  = (k == 0 && ab_unl >= 0) ? ab_unl + 1 : N2;
            for (int j = 0; j < nb; j++)
               sq[k].push_back('{c: L + lat_of(k) + 1 + j, b: cap[j]});
            if (!(k == 0 && ab_unl >= 0))
               dq[k].push_back(L + lat_of(k) + N2 + 1);
            mv[k] = fr;
         end
      end
      lat_max = sweep ? 255 : 3;
      while (cyc < L + lat_max + N2) begin
         if (ab_unl >= 0 && cyc == L + 3 + ab_unl) begin
            abort = 1'b1;
            start = 1'b0;
            step();
            abort = 1'b0;
            chk("abort_unl_sdov", FW'(sdov[0]), FW'(0));
            chk("abort_unl_busy", FW'(busy[0]), FW'(0));
            return;
         end
         start  = pulses && ($urandom_range(0, 7) == 0);
         svalid = 1'($urandom_range(0, 1));
         sdi    = 1'($urandom_range(0, 1));
         step();
      end
      start  = 1'b0;
      svalid = 1'b0;
      if (sweep) chk("busy_done_sweep", FW'(busy), FW'(0));
      else       chk("busy_done", FW'(busy[0]), FW'(0));
   endtask

   initial begin
      logic [FW-1:0] directed;
      rst      = 1'b1;
      start    = 1'b0;
      sw_start = 1'b0;
      abort    = 1'b0;
      sdi      = 1'b0;
      svalid   = 1'b0;
      cur_vec  = '0;
      for (int k = 0; k < 3; k++) mv[k] = '0;
      directed = {3'b101, 89'h1_2345_6789_ABCD_EF01_2345};

      repeat (3) step();
      chk("reset_vec", {ts3[0], ts2[0], ts1[0], tin[0]}, '0);
      chk("reset_ctl", FW'({busy, done, sdov, sdo}), '0);
      rst = 1'b0;
      step();

      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", FW'(busy[0]), FW'(0));
      step();

      run_txn(directed, 0, -1, -1, 1'b0, 1'b0);
      run_txn(directed, 5, -1, -1, 1'b0, 1'b0);
      run_txn(rnd_frame(), 0, -1, -1, 1'b0, 1'b1);

      repeat (4) begin
         run_txn(rnd_frame(), $urandom_range(0, 6), -1, -1, 1'b0, 1'b1);
         repeat ($urandom_range(0, 3)) step();
      end

      run_txn(rnd_frame(), 0, 40, -1, 1'b0, 1'b1);
      chk("abort_load_busy", FW'(busy[0]), FW'(0));
      repeat (3) step();
      run_txn(rnd_frame(), 2, -1, -1, 1'b0, 1'b0);

      run_txn(rnd_frame(), 0, -1, 10, 1'b0, 1'b0);
      repeat (3) step();

      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) begin
         svalid = 1'b1;
         sdi    = 1'($urandom_range(0, 1));
         step();
      end
      #2;
      abort = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      rst   = 1'b1;
      #1;
      chk("reset_async_vec", {ts3[0], ts2[0], ts1[0], tin[0]}, '0);
      chk("reset_async_ctl", FW'({busy, done, sdov, sdo}), '0);
      for (int k = 0; k < 3; k++) mv[k] = '0;
      abort  = 1'b0;
      start  = 1'b0;
      svalid = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      step();
      run_txn(rnd_frame(), 0, -1, -1, 1'b0, 1'b0);

      step();
      run_txn(rnd_frame(), 0, -1, -1, 1'b1, 1'b0);
      step();
      run_txn(rnd_frame(), 3, -1, -1, 1'b1, 1'b0);

      repeat (5) step();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("sdo_left_dut%0d", k), FW'(sq[k].size()), '0);
         chk($sformatf("done_left_dut%0d", k), FW'(dq[k].size()), '0);
      end
      chk("vec_left", FW'(vq.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tmodel_scan_ctrl.md
# tmodel_scan_ctrl

Serial test-access controller that drives the section test harness from a low-pin-count serial port. It deserializes a stimulus frame into the harness's wide parallel input and section-select lines, then holds the vector for a programmable settle time. It captures the harness's wide parallel result and serializes it back out. It sits between the chip-level test pins and the harness, on the same clock.

## Interface

- N1, 89, harness stimulus width (TIn)
- N2, 79, harness result width (TOut)
- LAT, 3, cycles between applying a vector and capturing TOut; legal range 1..255
- FW, N1+3, frame width (derived, not overridable)
- Clock  in  1  single clock, all logic on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  begin a transaction; sampled only in IDLE
- Abort  in  1  synchronous abort to IDLE; overrides all other inputs except Reset
- SDI  in  1  serial stimulus bit
- SValid  in  1  SDI qualifier; a bit is consumed only when SValid=1 in LOAD
- SDO  out  1  serial result bit
- SDOValid  out  1  SDO qualifier
- Busy  out  1  high in LOAD, APPLY, UNLOAD
- Done  out  1  one-cycle pulse on transaction completion
- TIn  out  N1  parallel stimulus to harness IN
- TS1, TS2, TS3  out  1 each  harness section selects
- TOut  in  N2  parallel result from harness OUT

## Operation

- Frame layout: bits [N1-1:0] are TIn, bit N1 is TS1, bit N1+1 is TS2, bit N1+2 is TS3. The frame shifts LSB first: the first consumed bit becomes frame[0].
- FSM states: IDLE, LOAD, APPLY, UNLOAD.
- IDLE:
  - Start=1 → LOAD; bit counter cleared.
  - SDI/SValid are ignored.
- LOAD:
  - Each SValid=1 cycle shifts the frame register right, with SDI entering at bit FW-1, and increments the bit counter.
  - SValid=0 stalls with no state change.
  - On the edge consuming bit FW-1 (the last bit): state → APPLY; TIn/TS1/TS2/TS3 load from the completed frame, including that bit; settle counter cleared.
- APPLY:
  - Counts LAT cycles.
  - On the edge ending the LAT-th APPLY cycle: TOut is captured into the result shift register; state → UNLOAD; bit counter cleared.
- UNLOAD:
  - SDOValid=1, SDO = result_sr[0]; the register shifts right each cycle.
  - Exactly N2 cycles, with no stall.
  - After bit N2-1: state → IDLE; Done=1 for the following single cycle.
- TIn/TS* are registered and change only on LOAD→APPLY. They hold their value through UNLOAD, IDLE and Abort, so the harness sees a stable vector.
- Start outside IDLE is ignored, with no queuing. Start and Abort asserted together in IDLE → stay IDLE.
- Abort in any state → IDLE next edge:
  - Bit counters clear.
  - SDOValid=0 and Done is not pulsed.
  - TIn/TS* are retained.
  - A partially loaded frame is discarded.
- Counter widths: $clog2(FW+1) for the bit counter, 8 bits for the settle counter.

## Timing

- Reset values: state IDLE, Busy=0, Done=0, SDO=0, SDOValid=0, TIn=0, TS1=TS2=TS3=0, internal registers 0.
- Reset asserted mid-transaction returns everything to the reset values immediately; no Done pulse.
- Start sampled at edge t0 → Busy=1 from cycle t0+1.
- With SValid held high, the last frame bit is consumed at edge t0+FW; TIn is valid from cycle t0+FW+1.
- TOut is captured at edge t0+FW+LAT. SDO bits 0..N2-1 appear in cycles t0+FW+LAT+1 .. t0+FW+LAT+N2.
- Done=1 and Busy=0 in cycle t0+FW+LAT+N2+1.
- Minimum transaction length is FW+LAT+N2+1 cycles from Start to Done; defaults give 92+3+79+1 = 175.
- Back-to-back: Start may be asserted in the Done cycle and is accepted.

## Test plan

- Reset: assert Reset mid-cycle with random inputs → all outputs zero asynchronously, Busy=0. After release, the first Start is accepted.
- Round trip, defaults:
  - Stub the harness with TOut = TIn[78:0] registered one cycle.
  - Shift the frame TIn=89'h1_2345_6789_ABCD_EF01_2345, TS3..TS1=3'b101, with SValid=1.
  - Expected: TIn/TS correct at cycle 93. SDO stream equals TIn[78:0] LSB first over 79 SDOValid cycles. Done at cycle 175.
- Stall: drop SValid for 5 random cycles during LOAD → identical TIn/SDO result, with Done delayed by exactly 5 cycles.
- Ignored Start: pulse Start during LOAD, APPLY and UNLOAD → no restart, bit counts unchanged. Start in the Done cycle → a new LOAD begins the next cycle.
- Abort: assert in LOAD at bit 40 → IDLE, TIn holds the previous vector, no Done. Assert in UNLOAD at bit 10 → SDOValid drops the next cycle, no Done.
- LAT sweep: LAT=1 and LAT=255 → TOut capture edge and first SDOValid cycle match the formulas in Timing.
